// File: rtl/tone_envelope.sv
// Attack/sustain/release envelope and 4-bit master volume, applied by PWM to a 1-bit tone.
// Build option: define TONE_ENV_EXP_RELEASE_EN for an exponential-like release instead of a linear one.
module tone_envelope #(
    parameter int unsigned ENV_DIV     = 1024,
    parameter int unsigned ATTACK_INC  = 8,
    parameter int unsigned RELEASE_DEC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tone_in,
    input  logic       gate,
    input  logic [3:0] vol,
    output logic       spk_out,
    output logic [7:0] level,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(ENV_DIV - 1);
    localparam logic [8:0]  ATT_STEP  = 9'(ATTACK_INC);
    localparam logic [7:0]  REL_STEP  = 8'(RELEASE_DEC);
    localparam logic [7:0]  LEVEL_MAX = 8'hFF;

    state_t      state;
    logic [15:0] prescaler;
    logic        tick;
    logic [8:0]  attack_sum;
    logic [7:0]  attack_level;
    logic [7:0]  release_step;
    logic [7:0]  release_level;
    logic [11:0] product;
    logic [7:0]  amp;
    logic [7:0]  pwm_cnt;
    logic [7:0]  amp_q;

    // Free-running envelope prescaler; gate activity never disturbs its phase.
    assign tick = (prescaler == DIV_LAST);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    // Candidate next levels, computed wide and saturated so they never wrap.
    always_comb begin
        // NOTE: every always_comb output is assigned unconditionally first, so no latch can be inferred.
        attack_sum   = {1'b0, level} + ATT_STEP;
        attack_level = attack_sum[8] ? LEVEL_MAX : attack_sum[7:0];
    end

`ifdef TONE_ENV_EXP_RELEASE_EN
    assign release_step = (level >> 3) + 8'd1;
`else
    assign release_step = REL_STEP;
`endif

    assign release_level = (level > release_step) ? (level - release_step) : 8'd0;

    // Envelope FSM; a gate change always wins over a coincident tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            level <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    level <= '0;
                    if (gate) begin
                        state <= ATTACK;
                        busy  <= 1'b1;
                    end
                end
                ATTACK: begin
                    if (!gate) begin
                        state <= RELEASE;
                    end else if (tick) begin
                        level <= attack_level;
                        if (attack_level == LEVEL_MAX) begin
                            state <= SUSTAIN;
                        end
                    end
                end
                SUSTAIN: begin
                    level <= LEVEL_MAX;
                    if (!gate) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (gate) begin
                        state <= ATTACK;
                    end else if (tick) begin
                        level <= release_level;
                        if (release_level == 8'd0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    level <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // vol is scaled as (vol+1)/16 so vol=0 is quiet but not silent.
    assign product = 12'(level) * 12'({1'b0, vol} + 5'd1);
    assign amp     = 8'(product >> 4);

    // amp_q only moves at the period boundary, so a duty cycle is never cut mid-period.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
            amp_q   <= '0;
            spk_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hFF) begin
                amp_q <= amp;
            end
            spk_out <= tone_in & (pwm_cnt < amp_q);
        end
    end

endmodule

// File: tb/tb_tone_envelope.sv
// Directed bench for tone_envelope: reset, attack, PWM volume, release, re-attack and gate/tick priority.
// Expected envelope levels come from the bench's own attack/release formulas (linear or exponential build).
module tb_tone_envelope;

    localparam int ENV_DIV     = 4;
    localparam int ATTACK_INC  = 8;
    localparam int RELEASE_DEC = 4;
    localparam int STEP_BUDGET = 2 * ENV_DIV + 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tone_in;
    logic       gate;
    logic [3:0] vol;
    logic       spk_out;
    logic [7:0] level;
    logic       busy;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] model_level;

    always #5 clk = ~clk;

    tone_envelope #(
        .ENV_DIV    (ENV_DIV),
        .ATTACK_INC (ATTACK_INC),
        .RELEASE_DEC(RELEASE_DEC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .tone_in(tone_in),
        .gate   (gate),
        .vol    (vol),
        .spk_out(spk_out),
        .level  (level),
        .busy   (busy)
    );

    function automatic logic [7:0] model_attack(input logic [7:0] lv);
        int s;
        s = int'(lv) + ATTACK_INC;
        return (s > 255) ? 8'hFF : 8'(s);
    endfunction

    function automatic logic [7:0] model_release(input logic [7:0] lv);
        int d;
`ifdef TONE_ENV_EXP_RELEASE_EN
        d = (int'(lv) / 8) + 1;
`else
        d = RELEASE_DEC;
`endif
        return (int'(lv) > d) ? 8'(int'(lv) - d) : 8'd0;
    endfunction

    // Waits (bounded) for level to leave prev; reports cycles taken.
    task automatic wait_step(input logic [7:0] prev, output int cycles, output bit timeout);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (level === prev && cycles < STEP_BUDGET);
        timeout = (level === prev);
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (spk_out === 1'b1) c++;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        gate    = 1'b1;
        tone_in = 1'b1;
        vol     = 4'd15;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (spk_out !== 1'b0 || level !== 8'd0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: spk=%b level=%0d busy=%b, want spk=0 level=0 busy=0",
                         spk_out, level, busy);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (level !== 8'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_attack: level=%0d busy=%b, want level=0 busy=1", level, busy);
        end
        model_level = 8'd0;
    endtask

    task automatic test_attack();
        int cyc;
        bit to;
        logic [7:0] exp_lv;
        for (int i = 1; i <= 32; i++) begin
            exp_lv = model_attack(model_level);
            wait_step(model_level, cyc, to);
            total++;
            if (to || level !== exp_lv || busy !== 1'b1 || (i > 1 && cyc != ENV_DIV)) begin
                bad++;
                $display("FAIL attack_step%0d: level=%0d busy=%b cycles=%0d timeout=%b, want level=%0d busy=1 cycles=%0d",
                         i, level, busy, cyc, to, exp_lv, ENV_DIV);
            end
            model_level = exp_lv;
        end
        repeat (3 * ENV_DIV) @(negedge clk);
        total++;
        if (level !== 8'hFF || busy !== 1'b1) begin
            bad++;
            $display("FAIL sustain_hold: level=%0d busy=%b, want level=255 busy=1", level, busy);
        end
    endtask

    task automatic test_volume_pwm();
        int c1;
        int c2;
        bit found;
        tone_in = 1'b1;
        vol     = 4'd15;
        repeat (512) @(negedge clk);
        count_high(256, c1);
        total++;
        if (c1 != 255) begin
            bad++;
            $display("FAIL duty_vol15: high=%0d of 256, want 255", c1);
        end
        vol = 4'd7;
        repeat (512) @(negedge clk);
        count_high(256, c1);
        total++;
        if (c1 != 127) begin
            bad++;
            $display("FAIL duty_vol7: high=%0d of 256, want 127", c1);
        end
        // The single low cycle of a full-scale period marks pwm_cnt==0.
        vol = 4'd15;
        repeat (512) @(negedge clk);
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (spk_out === 1'b0) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL period_marker: no low cycle within 300, want one low cycle per period");
        end
        c1 = 0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            if (spk_out === 1'b1) c1++;
            if (k == 100) vol = 4'd0;
        end
        count_high(256, c2);
        total++;
        if (c1 != 255 || c2 != 15) begin
            bad++;
            $display("FAIL duty_mid_period_change: cur_period=%0d next_period=%0d, want 255 and 15", c1, c2);
        end
        vol = 4'd15;
    endtask

    task automatic test_release();
        int cyc;
        int steps;
        int c;
        bit to;
        logic [7:0] exp_lv;
        gate = 1'b0;
        @(negedge clk);
        total++;
        if (level !== 8'hFF || busy !== 1'b1) begin
            bad++;
            $display("FAIL release_enter: level=%0d busy=%b, want level=255 busy=1", level, busy);
        end
        steps = 0;
        while (model_level != 8'd0 && steps < 300) begin
            steps++;
            exp_lv = model_release(model_level);
            wait_step(model_level, cyc, to);
            total++;
            if (to || level !== exp_lv || busy !== (exp_lv != 8'd0) || (steps > 1 && cyc != ENV_DIV)) begin
                bad++;
                $display("FAIL release_step%0d: level=%0d busy=%b cycles=%0d timeout=%b, want level=%0d busy=%b cycles=%0d",
                         steps, level, busy, cyc, to, exp_lv, (exp_lv != 8'd0), ENV_DIV);
            end
            model_level = exp_lv;
        end
        repeat (300) @(negedge clk);
        count_high(300, c);
        total++;
        if (c != 0 || level !== 8'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_silent: high=%0d level=%0d busy=%b, want high=0 level=0 busy=0", c, level, busy);
        end
    endtask

    task automatic test_reattack();
        int cyc;
        bit to;
        logic [7:0] exp_lv;
        gate = 1'b1;
        @(negedge clk);
        total++;
        if (level !== 8'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reattack_from_idle: level=%0d busy=%b, want level=0 busy=1", level, busy);
        end
        while (model_level != 8'hFF) begin
            exp_lv = model_attack(model_level);
            wait_step(model_level, cyc, to);
            total++;
            if (to || level !== exp_lv) begin
                bad++;
                $display("FAIL climb_step: level=%0d timeout=%b, want %0d", level, to, exp_lv);
            end
            model_level = exp_lv;
        end
        gate = 1'b0;
        while (model_level > 8'd156) begin
            exp_lv = model_release(model_level);
            wait_step(model_level, cyc, to);
            total++;
            if (to || level !== exp_lv) begin
                bad++;
                $display("FAIL fall_step: level=%0d timeout=%b, want %0d", level, to, exp_lv);
            end
            model_level = exp_lv;
        end
        // Raise the gate mid-release: attack resumes from the current level.
        gate = 1'b1;
        @(negedge clk);
        total++;
        if (level !== model_level || busy !== 1'b1) begin
            bad++;
            $display("FAIL reattack_hold: level=%0d busy=%b, want level=%0d busy=1", level, busy, model_level);
        end
        for (int i = 0; i < 2; i++) begin
            exp_lv = model_attack(model_level);
            wait_step(model_level, cyc, to);
            total++;
            if (to || level !== exp_lv || (i == 1 && cyc != ENV_DIV)) begin
                bad++;
                $display("FAIL reattack_step%0d: level=%0d cycles=%0d timeout=%b, want level=%0d",
                         i, level, cyc, to, exp_lv);
            end
            model_level = exp_lv;
        end
        // Drop the gate exactly on a tick cycle: no attack step may happen.
        repeat (3) @(negedge clk);
        gate = 1'b0;
        @(negedge clk);
        total++;
        if (level !== model_level || busy !== 1'b1) begin
            bad++;
            $display("FAIL gate_fall_on_tick: level=%0d busy=%b, want level=%0d busy=1", level, busy, model_level);
        end
        exp_lv = model_release(model_level);
        wait_step(model_level, cyc, to);
        total++;
        if (to || level !== exp_lv || cyc != ENV_DIV) begin
            bad++;
            $display("FAIL release_after_tick: level=%0d cycles=%0d timeout=%b, want level=%0d cycles=%0d",
                     level, cyc, to, exp_lv, ENV_DIV);
        end
        model_level = exp_lv;
        // Raise the gate exactly on a tick cycle: no release step may happen.
        repeat (3) @(negedge clk);
        gate = 1'b1;
        @(negedge clk);
        total++;
        if (level !== model_level || busy !== 1'b1) begin
            bad++;
            $display("FAIL gate_rise_on_tick: level=%0d busy=%b, want level=%0d busy=1", level, busy, model_level);
        end
        exp_lv = model_attack(model_level);
        wait_step(model_level, cyc, to);
        total++;
        if (to || level !== exp_lv || cyc != ENV_DIV) begin
            bad++;
            $display("FAIL attack_after_tick: level=%0d cycles=%0d timeout=%b, want level=%0d cycles=%0d",
                     level, cyc, to, exp_lv, ENV_DIV);
        end
        model_level = exp_lv;
    endtask

    task automatic test_tone_off();
        int cyc;
        int c;
        bit to;
        logic [7:0] exp_lv;
        tone_in = 1'b0;
        vol     = 4'd15;
        @(negedge clk);
        while (model_level != 8'hFF) begin
            exp_lv = model_attack(model_level);
            wait_step(model_level, cyc, to);
            total++;
            if (to || level !== exp_lv || spk_out !== 1'b0) begin
                bad++;
                $display("FAIL toneoff_step: level=%0d spk=%b timeout=%b, want level=%0d spk=0",
                         level, spk_out, to, exp_lv);
            end
            model_level = exp_lv;
        end
        count_high(300, c);
        total++;
        if (c != 0) begin
            bad++;
            $display("FAIL toneoff_silent: high=%0d of 300, want 0", c);
        end
    endtask

    task automatic test_reset_abort();
        tone_in = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (level !== 8'd0 || busy !== 1'b0 || spk_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort: level=%0d busy=%b spk=%b, want level=0 busy=0 spk=0",
                     level, busy, spk_out);
        end
        gate  = 1'b0;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (level !== 8'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_release: level=%0d busy=%b, want level=0 busy=0", level, busy);
        end
    endtask

    initial begin
        test_reset();
        test_attack();
        test_volume_pwm();
        test_release();
        test_reattack();
        test_tone_off();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
